// File: rtl/lstm_seq_pkg.sv
// Shared types and helpers for the LSTM layer sequencer.
package lstm_seq_pkg;

    // Sequencer phases for one layer run.
    typedef enum logic [2:0] {
        IDLE,
        ACC,
        DRAIN,
        WRITE,
        DONE
    } seq_state_e;

    // Length of the accumulate phase: the longer of the two dot products.
    function automatic int acc_len_f(input int n_input, input int n_cell);
        return (n_input > n_cell) ? n_input : n_cell;
    endfunction

endpackage

// File: rtl/lstm_addr_gen.sv
// One address stream: registered address = row base + saturating offset.
// The base moves by a fixed stride (no multipliers); the offset counts up
// and sticks at OFF_MAX so out-of-range terms keep their last valid address.
module lstm_addr_gen
    import lstm_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_INIT  = 0,
    parameter int BASE_STEP  = 1,
    parameter int OFF_MAX    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  show_i,
    input  logic                  base_load_i,
    input  logic                  base_step_i,
    input  logic                  off_clr_i,
    input  logic                  off_step_i,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    localparam logic [ADDR_WIDTH-1:0] INIT_V = ADDR_WIDTH'(BASE_INIT);
    localparam logic [ADDR_WIDTH-1:0] STEP_V = ADDR_WIDTH'(BASE_STEP);
    localparam logic [ADDR_WIDTH-1:0] OMAX_V = ADDR_WIDTH'(OFF_MAX);

    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] off_q, off_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // Next base/offset; the output shows their sum only while a run is active.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        base_d = base_q;
        off_d  = off_q;
        if (clr_i || base_load_i) begin
            base_d = INIT_V;
        end else if (base_step_i) begin
            base_d = base_q + STEP_V;
        end
        if (clr_i || off_clr_i) begin
            off_d = '0;
        end else if (off_step_i && (off_q != OMAX_V)) begin
            off_d = off_q + ADDR_WIDTH'(1);
        end
        addr_d = show_i ? (base_d + off_d) : '0;
    end

    // Stream registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            base_q <= INIT_V;
            off_q  <= '0;
            addr_q <= '0;
        end else begin
            base_q <= base_d;
            off_q  <= off_d;
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/lstm_layer_sequencer.sv
// Control sequencer for one LSTM layer: for every timestep t and cell j it
// runs ACC (k sweep), DRAIN (pipeline latency) and a one-cycle WRITE, then
// pulses done. All outputs are registered and clear on synchronous rst.
// Optional feature macro: LSTM_SEQ_SKIP_H0_EN (skip the recurrent term at t=0).
module lstm_layer_sequencer
    import lstm_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int TIMESTEP   = 7,
    parameter int N_INPUT    = 53,
    parameter int N_CELL     = 53,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  hold,
    output logic                  acc_x,
    output logic                  acc_h,
    output logic [ADDR_WIDTH-1:0] addr_x,
    output logic [ADDR_WIDTH-1:0] rd_addr_w,
    output logic [ADDR_WIDTH-1:0] rd_addr_u,
    output logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [ADDR_WIDTH-1:0] rd_addr_h,
    output logic [ADDR_WIDTH-1:0] rd_addr_c,
    output logic                  wr_h,
    output logic                  wr_c,
    output logic [ADDR_WIDTH-1:0] wr_addr_h,
    output logic [ADDR_WIDTH-1:0] wr_addr_c,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] timestep_idx,
    output logic [ADDR_WIDTH-1:0] cell_idx
);

`ifdef LSTM_SEQ_SKIP_H0_EN
    localparam bit SKIP_H0 = 1'b1;
`else
    localparam bit SKIP_H0 = 1'b0;
`endif

    localparam int ACC_LEN = acc_len_f(N_INPUT, N_CELL);
    localparam int LEN_T0  = SKIP_H0 ? N_INPUT : ACC_LEN;
    localparam int KW      = ADDR_WIDTH + 1;
    localparam int DW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [KW-1:0]         LEN_K     = KW'(ACC_LEN);
    localparam logic [KW-1:0]         LEN_T0_K  = KW'(LEN_T0);
    localparam logic [KW-1:0]         NI_K      = KW'(N_INPUT);
    localparam logic [KW-1:0]         NC_K      = KW'(N_CELL);
    localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(N_CELL - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_T    = ADDR_WIDTH'(TIMESTEP - 1);
    localparam logic [DW-1:0]         LAT_LAST  = DW'((LATENCY > 0) ? LATENCY - 1 : 0);

    // Every generated address must fit in the address space.
    localparam longint SPACE = longint'(1) << ADDR_WIDTH;
    if (((longint'(TIMESTEP) + 1) * N_CELL > SPACE) ||
        (longint'(TIMESTEP) * N_INPUT > SPACE) ||
        (longint'(N_CELL) * ACC_LEN > SPACE)) begin : g_size_check
        $error("lstm_layer_sequencer: layer dimensions exceed ADDR_WIDTH address space");
    end

    seq_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] t_q, t_d;
    logic [ADDR_WIDTH-1:0] j_q, j_d;
    logic [KW-1:0]         nxt_q, nxt_d;     // next k to present in ACC
    logic [DW-1:0]         cnt_q, cnt_d;     // DRAIN cycle counter
    logic                  acc_x_q, acc_x_d;
    logic                  acc_h_q, acc_h_d;
    logic                  wr_q, wr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Address-stream controls, valid for the edge being computed.
    logic run_clr;   // start of run: all streams to their initial row
    logic k_step;    // advance the k offset
    logic j_adv;     // next cell in the same timestep
    logic t_adv;     // wrap to cell 0 of the next timestep
    logic cell_new;
    logic show;

    logic [KW-1:0] cur_len;
    logic          skip_cur;

    assign skip_cur = SKIP_H0 && (t_q == '0);
    assign cur_len  = skip_cur ? LEN_T0_K : LEN_K;
    assign cell_new = j_adv || t_adv;
    assign show     = busy_d;

    // Next-state and registered-output decode for the sequencer.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        j_d     = j_q;
        nxt_d   = nxt_q;
        cnt_d   = cnt_q;
        acc_x_d = 1'b0;
        acc_h_d = 1'b0;
        wr_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        run_clr = 1'b0;
        k_step  = 1'b0;
        j_adv   = 1'b0;
        t_adv   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACC;
                    run_clr = 1'b1;
                    t_d     = '0;
                    j_d     = '0;
                    nxt_d   = KW'(1);
                    busy_d  = 1'b1;
                    acc_x_d = 1'b1;
                    acc_h_d = !SKIP_H0;
                end
            end
            ACC: begin
                if (hold) begin
                    // bubble: indices and addresses frozen, enables low
                end else if (nxt_q == cur_len) begin
                    cnt_d = '0;
                    if (LATENCY == 0) begin
                        state_d = WRITE;
                        wr_d    = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    k_step  = 1'b1;
                    nxt_d   = nxt_q + KW'(1);
                    acc_x_d = (nxt_q < NI_K);
                    acc_h_d = (nxt_q < NC_K) && !skip_cur;
                end
            end
            DRAIN: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = WRITE;
                    wr_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            WRITE: begin
                if ((j_q == LAST_CELL) && (t_q == LAST_T)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    t_d     = '0;
                    j_d     = '0;
                end else begin
                    if (j_q == LAST_CELL) begin
                        t_adv = 1'b1;
                        t_d   = t_q + ADDR_WIDTH'(1);
                        j_d   = '0;
                    end else begin
                        j_adv = 1'b1;
                        j_d   = j_q + ADDR_WIDTH'(1);
                    end
                    state_d = ACC;
                    nxt_d   = KW'(1);
                    acc_x_d = 1'b1;
                    acc_h_d = !(SKIP_H0 && (t_d == '0));
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer registers; rst clears the run and every output on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            j_q     <= '0;
            nxt_q   <= '0;
            cnt_q   <= '0;
            acc_x_q <= 1'b0;
            acc_h_q <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            j_q     <= j_d;
            nxt_q   <= nxt_d;
            cnt_q   <= cnt_d;
            acc_x_q <= acc_x_d;
            acc_h_q <= acc_h_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // x: t*N_INPUT + k
    lstm_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_INIT(0), .BASE_STEP(N_INPUT), .OFF_MAX(N_INPUT - 1))
    u_gen_x (.clk(clk), .rst(rst), .clr_i(run_clr), .show_i(show), .base_load_i(1'b0),
             .base_step_i(t_adv), .off_clr_i(cell_new), .off_step_i(k_step), .addr_o(addr_x));

    // W: j*N_INPUT + k
    lstm_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_INIT(0), .BASE_STEP(N_INPUT), .OFF_MAX(N_INPUT - 1))
    u_gen_w (.clk(clk), .rst(rst), .clr_i(run_clr), .show_i(show), .base_load_i(t_adv),
             .base_step_i(j_adv), .off_clr_i(cell_new), .off_step_i(k_step), .addr_o(rd_addr_w));

    // U: j*N_CELL + k
    lstm_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_INIT(0), .BASE_STEP(N_CELL), .OFF_MAX(N_CELL - 1))
    u_gen_u (.clk(clk), .rst(rst), .clr_i(run_clr), .show_i(show), .base_load_i(t_adv),
             .base_step_i(j_adv), .off_clr_i(cell_new), .off_step_i(k_step), .addr_o(rd_addr_u));

    // h read: t*N_CELL + k (row t is the previous timestep's output)
    lstm_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_INIT(0), .BASE_STEP(N_CELL), .OFF_MAX(N_CELL - 1))
    u_gen_h (.clk(clk), .rst(rst), .clr_i(run_clr), .show_i(show), .base_load_i(1'b0),
             .base_step_i(t_adv), .off_clr_i(cell_new), .off_step_i(k_step), .addr_o(rd_addr_h));

    // bias: j
    lstm_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_INIT(0), .BASE_STEP(1), .OFF_MAX(0))
    u_gen_b (.clk(clk), .rst(rst), .clr_i(run_clr), .show_i(show), .base_load_i(t_adv),
             .base_step_i(j_adv), .off_clr_i(1'b0), .off_step_i(1'b0), .addr_o(rd_addr_b));

    // c read: t*N_CELL + j
    lstm_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_INIT(0), .BASE_STEP(N_CELL), .OFF_MAX(N_CELL - 1))
    u_gen_c (.clk(clk), .rst(rst), .clr_i(run_clr), .show_i(show), .base_load_i(1'b0),
             .base_step_i(t_adv), .off_clr_i(t_adv), .off_step_i(j_adv), .addr_o(rd_addr_c));

    // h/c write: (t+1)*N_CELL + j
    lstm_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_INIT(N_CELL), .BASE_STEP(N_CELL), .OFF_MAX(N_CELL - 1))
    u_gen_wr (.clk(clk), .rst(rst), .clr_i(run_clr), .show_i(show), .base_load_i(1'b0),
              .base_step_i(t_adv), .off_clr_i(t_adv), .off_step_i(j_adv), .addr_o(wr_addr_h));

    assign wr_addr_c    = wr_addr_h;
    assign acc_x        = acc_x_q;
    assign acc_h        = acc_h_q;
    assign wr_h         = wr_q;
    assign wr_c         = wr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timestep_idx = t_q;
    assign cell_idx     = j_q;

endmodule

// File: tb/tb_lstm_layer_sequencer.sv
// Bench for lstm_layer_sequencer (N_INPUT=3, N_CELL=4, TIMESTEP=2, LATENCY=2).
// Honours LSTM_SEQ_SKIP_H0_EN when the RTL is built with it.
module tb_lstm_layer_sequencer;

    localparam int AW   = 12;
    localparam int T    = 2;
    localparam int NI   = 3;
    localparam int NC   = 4;
    localparam int LAT  = 2;
    localparam int MAXC = 512;

`ifdef LSTM_SEQ_SKIP_H0_EN
    localparam bit SKIP    = 1'b1;
    localparam int FW_BASE = 6,  LW_BASE = 52, DN_BASE = 53, FW_HOLD = 9,  DN_HOLD = 56;
`else
    localparam bit SKIP    = 1'b0;
    localparam int FW_BASE = 7,  LW_BASE = 56, DN_BASE = 57, FW_HOLD = 10, DN_HOLD = 60;
`endif

    logic clk = 1'b0;
    logic rst, start, hold;
    logic acc_x, acc_h, wr_h, wr_c, busy, done;
    logic [AW-1:0] addr_x, rd_addr_w, rd_addr_u, rd_addr_b, rd_addr_h, rd_addr_c;
    logic [AW-1:0] wr_addr_h, wr_addr_c, timestep_idx, cell_idx;

    always #5 clk = ~clk;

    lstm_layer_sequencer #(
        .ADDR_WIDTH(AW), .TIMESTEP(T), .N_INPUT(NI), .N_CELL(NC), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .acc_x(acc_x), .acc_h(acc_h),
        .addr_x(addr_x), .rd_addr_w(rd_addr_w), .rd_addr_u(rd_addr_u),
        .rd_addr_b(rd_addr_b), .rd_addr_h(rd_addr_h), .rd_addr_c(rd_addr_c),
        .wr_h(wr_h), .wr_c(wr_c), .wr_addr_h(wr_addr_h), .wr_addr_c(wr_addr_c),
        .busy(busy), .done(done), .timestep_idx(timestep_idx), .cell_idx(cell_idx)
    );

    typedef struct {
        int ax, aw, au, ab, ah, ac, awr, ti, ci;
        bit acc_x, acc_h, wr, busy, done;
    } exp_t;

    exp_t exp_q [MAXC];
    bit   hold_at [MAXC];   // hold value sampled at edge e
    bit   start_at [MAXC];  // start value sampled at edge e (run already started)
    int   n_cyc;
    int   n_checks = 0;
    int   n_errors = 0;
    int   obs_first_wr, obs_last_wr, obs_done, obs_wr_cnt, obs_done_cnt;
    int   obs_first_addr, obs_last_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Expected contents of a running cycle for timestep t, cell j, last index k.
    task automatic put_run(input int c, input int t, input int j, input int k);
        exp_q[c].ax   = t * NI + min2(k, NI - 1);
        exp_q[c].aw   = j * NI + min2(k, NI - 1);
        exp_q[c].au   = j * NC + min2(k, NC - 1);
        exp_q[c].ah   = t * NC + min2(k, NC - 1);
        exp_q[c].ab   = j;
        exp_q[c].ac   = t * NC + j;
        exp_q[c].awr  = (t + 1) * NC + j;
        exp_q[c].ti   = t;
        exp_q[c].ci   = j;
        exp_q[c].busy = 1'b1;
    endtask

    task automatic put_acc(input int c, input int t, input int j, input int k,
                           input bit active, input bit sk);
        put_run(c, t, j, k);
        exp_q[c].acc_x = active && (k < NI);
        exp_q[c].acc_h = active && (k < NC) && !sk;
    endtask

    // Walk the layer schedule: per cell, k sweep with hold bubbles, drain, write.
    task automatic build_model();
        int c, k, len;
        bit sk;
        for (int i = 0; i < MAXC; i++) exp_q[i] = '{default: 0};
        c = 1;
        for (int t = 0; t < T; t++) begin
            for (int j = 0; j < NC; j++) begin
                sk  = SKIP && (t == 0);
                len = sk ? NI : ((NI > NC) ? NI : NC);
                k   = 0;
                put_acc(c, t, j, k, 1'b1, sk);
                while (k < len) begin
                    if (hold_at[c]) begin
                        c++;
                        put_acc(c, t, j, k, 1'b0, sk);
                    end else begin
                        c++;
                        k++;
                        if (k < len) put_acc(c, t, j, k, 1'b1, sk);
                    end
                end
                for (int d = 0; d < LAT; d++) begin
                    put_run(c, t, j, len - 1);
                    c++;
                end
                put_run(c, t, j, len - 1);
                exp_q[c].wr = 1'b1;
                c++;
            end
        end
        exp_q[c].done = 1'b1;
        n_cyc = c + 3;
    endtask

    task automatic cmp_cycle(input string nm, input int c);
        string p;
        p = $sformatf("%s c%0d", nm, c);
        check({p, " acc_x"},     acc_x,        exp_q[c].acc_x);
        check({p, " acc_h"},     acc_h,        exp_q[c].acc_h);
        check({p, " addr_x"},    addr_x,       exp_q[c].ax);
        check({p, " rd_addr_w"}, rd_addr_w,    exp_q[c].aw);
        check({p, " rd_addr_u"}, rd_addr_u,    exp_q[c].au);
        check({p, " rd_addr_b"}, rd_addr_b,    exp_q[c].ab);
        check({p, " rd_addr_h"}, rd_addr_h,    exp_q[c].ah);
        check({p, " rd_addr_c"}, rd_addr_c,    exp_q[c].ac);
        check({p, " wr_h"},      wr_h,         exp_q[c].wr);
        check({p, " wr_c"},      wr_c,         exp_q[c].wr);
        check({p, " wr_addr_h"}, wr_addr_h,    exp_q[c].awr);
        check({p, " wr_addr_c"}, wr_addr_c,    exp_q[c].awr);
        check({p, " busy"},      busy,         exp_q[c].busy);
        check({p, " done"},      done,         exp_q[c].done);
        check({p, " t_idx"},     timestep_idx, exp_q[c].ti);
        check({p, " c_idx"},     cell_idx,     exp_q[c].ci);
    endtask

    task automatic check_zero(input string nm);
        check({nm, " acc_x"}, acc_x, 0);        check({nm, " acc_h"}, acc_h, 0);
        check({nm, " addr_x"}, addr_x, 0);      check({nm, " rd_addr_w"}, rd_addr_w, 0);
        check({nm, " rd_addr_u"}, rd_addr_u, 0); check({nm, " rd_addr_b"}, rd_addr_b, 0);
        check({nm, " rd_addr_h"}, rd_addr_h, 0); check({nm, " rd_addr_c"}, rd_addr_c, 0);
        check({nm, " wr_h"}, wr_h, 0);          check({nm, " wr_c"}, wr_c, 0);
        check({nm, " wr_addr_h"}, wr_addr_h, 0); check({nm, " wr_addr_c"}, wr_addr_c, 0);
        check({nm, " busy"}, busy, 0);          check({nm, " done"}, done, 0);
        check({nm, " t_idx"}, timestep_idx, 0); check({nm, " c_idx"}, cell_idx, 0);
    endtask

    // Start a run (start sampled at edge 0) and compare every cycle to the model.
    task automatic run_and_check(input string nm);
        build_model();
        obs_first_wr = -1; obs_last_wr = -1; obs_done = -1;
        obs_wr_cnt = 0; obs_done_cnt = 0; obs_first_addr = -1; obs_last_addr = -1;
        start = 1'b1;
        hold  = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= n_cyc; c++) begin
            start = start_at[c];
            hold  = hold_at[c];
            @(negedge clk);
            cmp_cycle(nm, c);
            if (wr_h === 1'b1) begin
                obs_wr_cnt++;
                if (obs_first_wr < 0) begin
                    obs_first_wr   = c;
                    obs_first_addr = int'(wr_addr_h);
                end
                obs_last_wr   = c;
                obs_last_addr = int'(wr_addr_h);
            end
            if (done === 1'b1) begin
                obs_done_cnt++;
                obs_done = c;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        hold  = 1'b0;
        check({nm, " write_count"}, obs_wr_cnt, T * NC);
        check({nm, " done_count"}, obs_done_cnt, 1);
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            hold_at[i]  = 1'b0;
            start_at[i] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        clear_stim();

        // power-on reset
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_zero("por");
        rst = 1'b0;

        // reset asserted mid-run for three cycles
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_zero($sformatf("midrst%0d", i));
        end
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_zero("post_rst");

        // plain run
        run_and_check("base");
        check("base first_wr_cycle", obs_first_wr, FW_BASE);
        check("base first_wr_addr", obs_first_addr, NC);
        check("base last_wr_cycle", obs_last_wr, LW_BASE);
        check("base last_wr_addr", obs_last_addr, (T + 1) * NC - 1);
        check("base done_cycle", obs_done, DN_BASE);

        // hold sampled at edges 1..3 of the first cell
        clear_stim();
        for (int e = 1; e <= 3; e++) hold_at[e] = 1'b1;
        run_and_check("hold");
        check("hold first_wr_cycle", obs_first_wr, FW_HOLD);
        check("hold done_cycle", obs_done, DN_HOLD);

        // start pulsed while busy must be ignored
        clear_stim();
        start_at[20] = 1'b1;
        run_and_check("busy_start");

        // random hold patterns and stray start pulses
        for (int r = 0; r < 4; r++) begin
            clear_stim();
            for (int e = 1; e < 300; e++) hold_at[e] = ($urandom_range(0, 3) == 0);
            for (int e = 1; e < 50; e++) start_at[e] = ($urandom_range(0, 7) == 0);
            run_and_check($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
